// File: rtl/debug_slave_cmd_sync.sv
// debug_slave_cmd_sync
// Brings JTAG-domain debug commands into the system clock domain. An update
// toggle is synchronized and edge-detected. Each detected edge captures the
// (stable) scanned data and IR code into a small first-word-fall-through FIFO.
// Popping the head produces a held jdo word and a one-cycle per-IR pulse on
// take_action or take_no_action, selected by the jdo MSB.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   sr_in, ir_in      scanned data / IR code from the JTAG domain
//   upd_toggle        JTAG-domain level, flips once per update-DR
//   cmd_valid/ready   FIFO head handshake
//   cmd_data, cmd_ir  FIFO head contents
//   jdo               data of the last popped command
//   take_action       one-hot pulse on popped IR channel, action bit set
//   take_no_action    one-hot pulse on popped IR channel, action bit clear
//   fifo_level        current entry count
//   overrun, ovr_clr  sticky dropped-command flag and its clear
module debug_slave_cmd_sync #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             sr_in,
    input  logic [IR_W-1:0]               ir_in,
    input  logic                          upd_toggle,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [DATA_W-1:0]             cmd_data,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [DATA_W-1:0]             jdo,
    output logic [(2**IR_W)-1:0]          take_action,
    output logic [(2**IR_W)-1:0]          take_no_action,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          ovr_clr
);

    localparam int unsigned NumCh = 2 ** IR_W;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned EntW  = IR_W + DATA_W;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   evt;

    logic [EntW-1:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]        level_q, level_d;
    logic                   full, push, pop, drop;

    logic [DATA_W-1:0]      jdo_q;
    logic [NumCh-1:0]       act_q, noact_q, onehot;
    logic                   ovr_q;

    // Toggle synchronizer. During reset every stage follows the input so the
    // level present at release does not look like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{upd_toggle}};
            edge_q <= upd_toggle;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], upd_toggle};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign evt = sync_q[SYNC_STAGES-1] ^ edge_q;

    assign full = (level_q == LvlW'(FIFO_DEPTH));
    assign pop  = cmd_valid & cmd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = evt & (~full | pop);
    assign drop = evt & full & ~pop;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {ir_in, sr_in};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            level_q <= level_d;
        end
    end

    assign cmd_valid  = (level_q != '0);
    assign cmd_data   = mem_q[rd_ptr_q][DATA_W-1:0];
    assign cmd_ir     = mem_q[rd_ptr_q][EntW-1:DATA_W];
    assign fifo_level = level_q;

    assign onehot = {{(NumCh-1){1'b0}}, 1'b1} << cmd_ir;

    always_ff @(posedge clk) begin
        if (reset) begin
            jdo_q   <= '0;
            act_q   <= '0;
            noact_q <= '0;
        end else if (pop) begin
            jdo_q <= cmd_data;
            if (cmd_data[DATA_W-1]) begin
                act_q   <= onehot;
                noact_q <= '0;
            end else begin
                act_q   <= '0;
                noact_q <= onehot;
            end
        end else begin
            act_q   <= '0;
            noact_q <= '0;
        end
    end

    // A drop wins over a coincident clear so no overrun is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q <= 1'b0;
        end else if (drop) begin
            ovr_q <= 1'b1;
        end else if (ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// Directed self-checking bench for debug_slave_cmd_sync (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_debug_slave_cmd_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] sr_in;
    logic [1:0]  ir_in;
    logic        upd_toggle;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [37:0] cmd_data;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic [2:0]  fifo_level;
    logic        overrun;
    logic        ovr_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debug_slave_cmd_sync dut (
        .clk            (clk),
        .reset          (reset),
        .sr_in          (sr_in),
        .ir_in          (ir_in),
        .upd_toggle     (upd_toggle),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .fifo_level     (fifo_level),
        .overrun        (overrun),
        .ovr_clr        (ovr_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a command and flip the toggle; wait long enough for capture.
    task automatic send(input logic [37:0] d, input logic [1:0] ir);
        sr_in      = d;
        ir_in      = ir;
        upd_toggle = ~upd_toggle;
        step(4);
    endtask

    initial begin
        reset      = 1'b1;
        sr_in      = '0;
        ir_in      = '0;
        upd_toggle = 1'b0;
        cmd_ready  = 1'b1;
        ovr_clr    = 1'b0;
        step(3);

        // Reset state
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_jdo", 64'(jdo), 64'd0);
        check("rst_act", 64'(take_action), 64'd0);
        check("rst_noact", 64'(take_no_action), 64'd0);
        check("rst_ovr", 64'(overrun), 64'd0);
        check("rst_data", 64'(cmd_data), 64'd0);
        reset = 1'b0;
        step(2);

        // Action command, IR 2: latency and pulse width
        sr_in      = 38'h20000000AB;
        ir_in      = 2'd2;
        upd_toggle = 1'b1;
        step(1);
        check("lat_k", 64'(cmd_valid), 64'd0);
        step(1);
        check("lat_k1", 64'(cmd_valid), 64'd0);
        step(1);
        check("lat_k2_valid", 64'(cmd_valid), 64'd1);
        check("lat_k2_data", 64'(cmd_data), 64'h20000000AB);
        check("lat_k2_ir", 64'(cmd_ir), 64'd2);
        step(1);
        check("act_jdo", 64'(jdo), 64'h20000000AB);
        check("act_pulse", 64'(take_action), 64'b0100);
        check("act_noact", 64'(take_no_action), 64'd0);
        check("act_valid_off", 64'(cmd_valid), 64'd0);
        step(1);
        check("act_end", 64'(take_action), 64'd0);
        check("act_jdo_hold", 64'(jdo), 64'h20000000AB);

        // No-action command, IR 1
        sr_in      = 38'h0000000055;
        ir_in      = 2'd1;
        upd_toggle = 1'b0;
        step(4);
        check("noact_pulse", 64'(take_no_action), 64'b0010);
        check("noact_act", 64'(take_action), 64'd0);
        check("noact_jdo", 64'(jdo), 64'h55);
        step(1);
        check("noact_end", 64'(take_no_action), 64'd0);

        // Fill, overflow, drain in order
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(38'(16 + i), 2'(i));
        check("fill_level", 64'(fifo_level), 64'd4);
        check("fill_ovr", 64'(overrun), 64'd0);
        send(38'h3F, 2'd0);
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_ovr", 64'(overrun), 64'd1);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_ir", 64'(cmd_ir), 64'(i));
            check("drain_data", 64'(cmd_data), 64'(16 + i));
            step(1);
            check("drain_jdo", 64'(jdo), 64'(16 + i));
            check("drain_noact", 64'(take_no_action), 64'(4'b0001 << i));
        end
        check("drain_level", 64'(fifo_level), 64'd0);
        check("drain_valid", 64'(cmd_valid), 64'd0);
        check("ovr_sticky", 64'(overrun), 64'd1);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        check("ovr_clr", 64'(overrun), 64'd0);

        // Full FIFO, push and pop on the same edge
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(38'(32 + i), 2'(i));
        sr_in      = 38'h2000000099;
        ir_in      = 2'd2;
        upd_toggle = ~upd_toggle;
        step(2);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check("pp_level", 64'(fifo_level), 64'd4);
        check("pp_ovr", 64'(overrun), 64'd0);
        check("pp_jdo", 64'(jdo), 64'd32);
        step(1);
        cmd_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check("pp_ir", 64'(cmd_ir), 64'(i));
            step(1);
            check("pp_jdo_seq", 64'(jdo), 64'(32 + i));
        end
        check("pp_last_ir", 64'(cmd_ir), 64'd2);
        check("pp_last_data", 64'(cmd_data), 64'h2000000099);
        step(1);
        check("pp_last_act", 64'(take_action), 64'b0100);
        check("pp_empty", 64'(fifo_level), 64'd0);

        // Toggle level held high across reset release: no spurious command
        reset      = 1'b1;
        upd_toggle = 1'b1;
        step(3);
        reset = 1'b0;
        step(5);
        check("rel_valid", 64'(cmd_valid), 64'd0);
        check("rel_act", 64'(take_action | take_no_action), 64'd0);
        cmd_ready = 1'b0;
        send(38'h12, 2'd3);
        check("rel_one", 64'(fifo_level), 64'd1);
        step(4);
        check("rel_still_one", 64'(fifo_level), 64'd1);
        cmd_ready = 1'b1;
        step(1);
        check("rel_pop_noact", 64'(take_no_action), 64'b1000);
        check("rel_pop_level", 64'(fifo_level), 64'd0);

        // Reset with entries queued
        cmd_ready = 1'b0;
        send(38'h21, 2'd1);
        send(38'h22, 2'd2);
        check("q2_level", 64'(fifo_level), 64'd2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("q2_rst_level", 64'(fifo_level), 64'd0);
        check("q2_rst_valid", 64'(cmd_valid), 64'd0);
        check("q2_rst_jdo", 64'(jdo), 64'd0);
        step(4);
        check("q2_no_event", 64'(fifo_level), 64'd0);

        // Clear coincident with a drop keeps overrun set
        for (int i = 0; i < 5; i++) send(38'(48 + i), 2'(i));
        check("oc_set", 64'(overrun), 64'd1);
        sr_in      = 38'h7;
        upd_toggle = ~upd_toggle;
        step(2);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        check("oc_drop_wins", 64'(overrun), 64'd1);
        check("oc_level", 64'(fifo_level), 64'd4);
        step(2);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        check("oc_clear", 64'(overrun), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
